// File: rtl/integral_row_stream.sv
// integral_row_stream: streaming integral-image generator.
// One raster-order pixel in per valid cycle, I(x,y) out two cycles later.
// A one-row line buffer holds the previous row's integrals; sums wrap modulo
// 2^SUM_WIDTH. SQUARE_MODE=1 accumulates p*p for variance normalisation.
module integral_row_stream #(
   parameter int DATA_WIDTH  = 8,
   parameter int SUM_WIDTH   = 24,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int ADDR_WIDTH  = 10,
   parameter int ROW_WIDTH   = 9,
   parameter int SQUARE_MODE = 0
) (
   input  logic                  clk_os,
   input  logic                  reset_os,
   input  logic                  i_valid,
   input  logic                  i_sof,
   input  logic [DATA_WIDTH-1:0] i_pixel,
   output logic                  o_valid,
   output logic [SUM_WIDTH-1:0]  o_integral,
   output logic [ADDR_WIDTH-1:0] o_col,
   output logic [ROW_WIDTH-1:0]  o_row,
   output logic                  o_eol,
   output logic                  o_eof
);

   localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
   localparam logic [ROW_WIDTH-1:0]  ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 1);

   // position counters of the next pixel to be accepted
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   logic [ROW_WIDTH-1:0]  row_q, row_d;
   logic                  first_q, first_d;
   // running sum along the current row; holds the stage-1 pixel's rowsum
   logic [SUM_WIDTH-1:0]  rowsum_q, rowsum_d;

   // coordinates of the pixel presented this cycle (sof overrides counters)
   logic [ADDR_WIDTH-1:0] cur_col;
   logic [ROW_WIDTH-1:0]  cur_row;
   logic                  cur_first;
   logic                  cur_eol;
   logic                  cur_eof;

   logic [2*DATA_WIDTH-1:0] pix_sq;
   logic [SUM_WIDTH-1:0]    term;

   // stage 1
   logic                  s1_valid_q;
   logic [ADDR_WIDTH-1:0] s1_col_q;
   logic [ROW_WIDTH-1:0]  s1_row_q;
   logic                  s1_first_q;
   logic                  s1_eol_q;
   logic                  s1_eof_q;
   logic [SUM_WIDTH-1:0]  rd_q;

   // stage 2
   logic [SUM_WIDTH-1:0]  sum_s2;
   logic                  out_valid_q;
   logic [SUM_WIDTH-1:0]  out_integral_q;
   logic [ADDR_WIDTH-1:0] out_col_q;
   logic [ROW_WIDTH-1:0]  out_row_q;
   logic                  out_eol_q;
   logic                  out_eof_q;

   logic [SUM_WIDTH-1:0]  line_mem [IMG_WIDTH];

   // resolve the current pixel position and its accumulation term
   always_comb begin
      cur_col   = i_sof ? '0 : col_q;
      cur_row   = i_sof ? '0 : row_q;
      cur_first = i_sof | first_q;
      cur_eol   = (cur_col == COL_LAST);
      cur_eof   = cur_eol && (cur_row == ROW_LAST);
      pix_sq    = {{DATA_WIDTH{1'b0}}, i_pixel} * {{DATA_WIDTH{1'b0}}, i_pixel};
      term      = (SQUARE_MODE != 0) ? SUM_WIDTH'(pix_sq) : SUM_WIDTH'(i_pixel);
   end

   // next-state for counters, first-row flag and row sum
   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      first_d  = first_q;
      rowsum_d = rowsum_q;
      if (i_valid) begin
         if (cur_eol) begin
            col_d   = '0;
            row_d   = cur_eof ? '0 : cur_row + ROW_WIDTH'(1);
            // leaving the last row re-arms the mask for the next frame's row 0
            first_d = cur_eof;
         end else begin
            col_d   = cur_col + ADDR_WIDTH'(1);
            row_d   = cur_row;
            first_d = cur_first;
         end
         rowsum_d = (cur_col == '0) ? term : rowsum_q + term;
      end
   end

   // counter and row-sum registers
   always_ff @(posedge clk_os) begin
      if (reset_os) begin
         col_q    <= '0;
         row_q    <= '0;
         first_q  <= 1'b1;
         rowsum_q <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         first_q  <= first_d;
         rowsum_q <= rowsum_d;
      end
   end

   // stage 1: capture position and flags of the accepted pixel
   always_ff @(posedge clk_os) begin
      if (reset_os) begin
         s1_valid_q <= 1'b0;
         s1_col_q   <= '0;
         s1_row_q   <= '0;
         s1_first_q <= 1'b1;
         s1_eol_q   <= 1'b0;
         s1_eof_q   <= 1'b0;
      end else begin
         s1_valid_q <= i_valid;
         if (i_valid) begin
            s1_col_q   <= cur_col;
            s1_row_q   <= cur_row;
            s1_first_q <= cur_first;
            s1_eol_q   <= cur_eol;
            s1_eof_q   <= cur_eof;
         end
      end
   end

   // line buffer: read the row above in stage 1, write back the new integral in stage 2
   always_ff @(posedge clk_os) begin
      rd_q <= line_mem[cur_col];
      if (s1_valid_q) begin
         line_mem[s1_col_q] <= sum_s2;
      end
   end

   // stage 2 adder; row 0 ignores whatever the RAM still holds
   always_comb begin
      sum_s2 = rowsum_q + (s1_first_q ? '0 : rd_q);
   end

   // stage 2: output registers
   always_ff @(posedge clk_os) begin
      if (reset_os) begin
         out_valid_q    <= 1'b0;
         out_integral_q <= '0;
         out_col_q      <= '0;
         out_row_q      <= '0;
         out_eol_q      <= 1'b0;
         out_eof_q      <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_integral_q <= sum_s2;
            out_col_q      <= s1_col_q;
            out_row_q      <= s1_row_q;
            out_eol_q      <= s1_eol_q;
            out_eof_q      <= s1_eof_q;
         end
      end
   end

   assign o_valid    = out_valid_q;
   assign o_integral = out_integral_q;
   assign o_col      = out_col_q;
   assign o_row      = out_row_q;
   assign o_eol      = out_eol_q;
   assign o_eof      = out_eof_q;

endmodule

// File: tb/tb_integral_row_stream.sv
// Testbench for integral_row_stream: three DUT configurations share one input
// stream; a summation reference model fills per-DUT scoreboards, a negedge
// monitor pops and compares.
module tb_integral_row_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_valid = 1'b0;
   logic       i_sof = 1'b0;
   logic [7:0] i_pixel = '0;

   // DUT A: W4 H3 SUM24 linear
   logic a_valid, a_eol, a_eof;
   logic [23:0] a_int;
   logic [1:0]  a_col;
   logic [1:0]  a_row;
   // DUT B: W4 H2 SUM24 squared
   logic b_valid, b_eol, b_eof;
   logic [23:0] b_int;
   logic [1:0]  b_col;
   logic [0:0]  b_row;
   // DUT C: W4 H4 SUM8 linear (wraps)
   logic c_valid, c_eol, c_eof;
   logic [7:0]  c_int;
   logic [1:0]  c_col;
   logic [1:0]  c_row;

   integral_row_stream #(.DATA_WIDTH(8), .SUM_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(3),
      .ADDR_WIDTH(2), .ROW_WIDTH(2), .SQUARE_MODE(0)) dut_a (
      .clk_os(clk), .reset_os(rst), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
      .o_valid(a_valid), .o_integral(a_int), .o_col(a_col), .o_row(a_row),
      .o_eol(a_eol), .o_eof(a_eof));

   integral_row_stream #(.DATA_WIDTH(8), .SUM_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(2),
      .ADDR_WIDTH(2), .ROW_WIDTH(1), .SQUARE_MODE(1)) dut_b (
      .clk_os(clk), .reset_os(rst), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
      .o_valid(b_valid), .o_integral(b_int), .o_col(b_col), .o_row(b_row),
      .o_eol(b_eol), .o_eof(b_eof));

   integral_row_stream #(.DATA_WIDTH(8), .SUM_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4),
      .ADDR_WIDTH(2), .ROW_WIDTH(2), .SQUARE_MODE(0)) dut_c (
      .clk_os(clk), .reset_os(rst), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
      .o_valid(c_valid), .o_integral(c_int), .o_col(c_col), .o_row(c_row),
      .o_eol(c_eol), .o_eof(c_eof));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     cyc;
      longint val;
      int     col;
      int     row;
      bit     eol;
      bit     eof;
   } exp_t;

   exp_t   sbq [3][$];
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b0;

   // model configuration and state
   int     MW = 4;
   int     MH [3] = '{3, 2, 4};
   int     MSW[3] = '{24, 24, 8};
   int     MSQ[3] = '{0, 1, 0};
   int     mcol[3];
   int     mrow[3];
   longint term[3][4][4];

   // reference: I(x,y) is the plain sum of all terms up to (x,y) in the current frame
   task automatic model_accept(input bit s, input int p);
      for (int k = 0; k < 3; k++) begin
         exp_t   e;
         longint sum;
         if (s) begin
            mcol[k] = 0;
            mrow[k] = 0;
         end
         term[k][mcol[k]][mrow[k]] = (MSQ[k] != 0) ? longint'(p) * longint'(p) : longint'(p);
         sum = 0;
         for (int j = 0; j <= mrow[k]; j++)
            for (int i = 0; i <= mcol[k]; i++)
               sum += term[k][i][j];
         e.cyc = cyc + 2;
         e.val = sum % (longint'(1) << MSW[k]);
         e.col = mcol[k];
         e.row = mrow[k];
         e.eol = (mcol[k] == MW - 1);
         e.eof = e.eol && (mrow[k] == MH[k] - 1);
         sbq[k].push_back(e);
         mcol[k]++;
         if (mcol[k] == MW) begin
            mcol[k] = 0;
            mrow[k]++;
            if (mrow[k] == MH[k]) mrow[k] = 0;
         end
      end
   endtask

   task automatic step(input bit v, input bit s, input int p);
      i_valid = v;
      i_sof   = s;
      i_pixel = 8'(p);
      if (v) model_accept(s, p);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   task automatic stream(input int n, input int p, input bit sof_first, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0, 0);
         step(1'b1, sof_first && (i == 0), p);
      end
   endtask

   // synchronous reset: everything due after the reset edge is discarded
   task automatic do_reset(input int ncyc);
      rst     = 1'b1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         while (sbq[k].size() > 0 && sbq[k][$].cyc > cyc) void'(sbq[k].pop_back());
         mcol[k] = 0;
         mrow[k] = 0;
      end
      repeat (ncyc) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   // monitor: compare whatever each DUT presents with its scoreboard head
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            logic   v, eol, eof;
            longint val;
            int     c, r;
            bit     due;
            exp_t   e;
            case (k)
               0: begin v = a_valid; val = longint'(a_int); c = int'(a_col); r = int'(a_row); eol = a_eol; eof = a_eof; end
               1: begin v = b_valid; val = longint'(b_int); c = int'(b_col); r = int'(b_row); eol = b_eol; eof = b_eof; end
               default: begin v = c_valid; val = longint'(c_int); c = int'(c_col); r = int'(c_row); eol = c_eol; eof = c_eof; end
            endcase
            while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
               e = sbq[k].pop_front();
               checks++;
               errors++;
               $display("FAIL dut%0d stale_expect cyc=%0d (x=%0d,y=%0d) never presented", k, e.cyc, e.col, e.row);
            end
            due = (sbq[k].size() > 0) && (sbq[k][0].cyc == cyc);
            checks++;
            if (v !== due) begin
               errors++;
               $display("FAIL dut%0d o_valid cyc=%0d got=%b want=%b", k, cyc, v, due);
            end
            if (due) begin
               e = sbq[k].pop_front();
               if (v === 1'b1) begin
                  checks++;
                  if (val !== e.val) begin
                     errors++;
                     $display("FAIL dut%0d integral (%0d,%0d) got=%0d want=%0d", k, e.col, e.row, val, e.val);
                  end
                  checks++;
                  if (c != e.col || r != e.row) begin
                     errors++;
                     $display("FAIL dut%0d coords got=(%0d,%0d) want=(%0d,%0d)", k, c, r, e.col, e.row);
                  end
                  checks++;
                  if (eol !== e.eol || eof !== e.eof) begin
                     errors++;
                     $display("FAIL dut%0d eol_eof (%0d,%0d) got=%b%b want=%b%b", k, e.col, e.row, eol, eof, e.eol, e.eof);
                  end
               end
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         mcol[k] = 0;
         mrow[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      // reset values of every output
      checks++;
      if ({a_valid, a_int, a_col, a_row, a_eol, a_eof} !== '0) begin
         errors++;
         $display("FAIL dut0 reset_outputs got=%h want=0", {a_valid, a_int, a_col, a_row, a_eol, a_eof});
      end
      checks++;
      if ({b_valid, b_int, b_col, b_row, b_eol, b_eof} !== '0) begin
         errors++;
         $display("FAIL dut1 reset_outputs got=%h want=0", {b_valid, b_int, b_col, b_row, b_eol, b_eof});
      end
      checks++;
      if ({c_valid, c_int, c_col, c_row, c_eol, c_eof} !== '0) begin
         errors++;
         $display("FAIL dut2 reset_outputs got=%h want=0", {c_valid, c_int, c_col, c_row, c_eol, c_eof});
      end
      mon_en = 1'b1;

      // all-ones frame, back to back
      stream(12, 1, 1'b1, 0);
      // all-ones with about 40% idle cycles
      stream(24, 1, 1'b1, 40);
      // saturating pixels: wrap on the 8-bit sum
      stream(16, 255, 1'b1, 0);
      // all 3s, squared mode gives 9..72 on its 4x2 frame
      stream(8, 3, 1'b1, 0);
      // reset at (2,1) of a ones frame, then a fresh frame without sof
      stream(6, 1, 1'b1, 0);
      do_reset(2);
      stream(12, 1, 1'b0, 0);
      // 2s frame straight after eof, then sof at (1,1) of the next frame
      stream(12, 2, 1'b0, 0);
      stream(5, 1, 1'b0, 0);
      step(1'b1, 1'b1, 7);
      stream(10, 4, 1'b0, 10);
      // randomized traffic with sporadic sof and reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset(1);
         end else begin
            bit v;
            v = ($urandom_range(0, 99) < 70);
            step(v, v && ($urandom_range(0, 99) < 4), $urandom_range(0, 255));
         end
      end
      // drain the pipeline
      repeat (5) step(1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (sbq[k].size() != 0) begin
            errors++;
            $display("FAIL dut%0d drain pending=%0d want=0", k, sbq[k].size());
         end
      end
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
